alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin controller that shares one combinational 4-bit `alu` instance between two clients. It accepts operations over a valid/ready handshake and drives the ALU operand and opcode inputs from registers. It captures `y`/`v` one cycle later, sanitises the flags, and returns the result to the owning requester over a held response handshake. It sits between the ALU and the two client blocks. The `alu` is instantiated outside this block and wired to its `alu_*` ports.

## Interface
Parameters: none (widths fixed by the ALU: 4-bit operands/result, 4-bit opcode).

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1 each  operation request from requester 0 / 1
- `req0_ready`, `req1_ready`  out  1 each  request accepted (combinational)
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  4 each  operands
- `req0_op`, `req1_op`  in  4 each  ALU opcode
- `rsp_valid`  out  2  one-hot; bit i = result pending for requester i
- `rsp_ready`  in  2  bit i = requester i takes the result
- `rsp_y`  out  4  result
- `rsp_v`  out  1  carry/borrow/shift-out flag (sanitised)
- `rsp_err`  out  1  operation error
- `alu_a`, `alu_b`, `alu_op`  out  4 each  to ALU inputs (registered)
- `alu_y`  in  4  from ALU
- `alu_v`  in  1  from ALU
- `busy`  out  1  high in every state except IDLE
- `done_cnt`  out  8  completed-response counter, wraps 255→0

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not served last. The pointer resets to favour requester 0.
  - `reqN_ready` = (state==IDLE) & grantN. It is combinational and never high for both requesters.
  - On an accept edge: latch a/b/op into `alu_a`/`alu_b`/`alu_op`, record the owner, update the RR pointer to "owner served last", go to EXEC.
- EXEC (one cycle): the ALU settles on the registered inputs. At the edge:
  - `rsp_y` ← `alu_y`.
  - `rsp_v` ← `alu_v` only for op ∈ {1000, 1001, 1011, 1100}; otherwise 0. This masks the ALU's stale `v`.
  - `rsp_err` ← 1 if op==0111 (undefined) or (op==1010 and b==0). When `rsp_err` is set, `rsp_y` ← 0 and `rsp_v` ← 0.
  - Go to RESP.
- RESP:
  - `rsp_valid[owner]`=1. `rsp_y`/`rsp_v`/`rsp_err` are held stable.
  - `rsp_ready` of the non-owner is ignored.
  - On `rsp_ready[owner]`: increment `done_cnt`, clear `rsp_valid`, go to IDLE.
- `alu_a`/`alu_b`/`alu_op` hold their last values outside EXEC.
- Request valid is sampled only in IDLE. Withdrawal before accept is permitted and has no effect.
- Reset (asynchronous, any state, including mid-EXEC/RESP):
  - state=IDLE, pointer favours 0.
  - `rsp_valid`=00; `rsp_y`, `rsp_v`, `rsp_err`=0.
  - `alu_a`, `alu_b`, `alu_op`=0.
  - `done_cnt`=0, `busy`=0.
  - The in-flight operation is discarded.

## Timing
- Accept at edge T → result registered at T+1 → `rsp_valid` high from T+1 (visible in cycle after T+1).
- `rsp_ready` sampled at edge T+2 at the earliest → IDLE in cycle after T+2. The next accept is possible at edge T+3.
- Peak throughput: one operation per 3 cycles.
- No bypass:
  - `rsp_ready` together with a pending request costs one IDLE cycle before the next accept.
  - `reqN_ready` is low throughout EXEC/RESP.
- Backpressure: RESP is held indefinitely with outputs stable.
- `done_cnt` increments exactly on the response-handshake edge.

## Test plan
- Requester 0: a=9, b=8, op=1000; hold `rsp_ready`=1 → `rsp_valid`=01 two cycles after accept, `rsp_y`=1, `rsp_v`=1, `rsp_err`=0, `done_cnt`=1.
- Add (1000, 9+8), then requester 1 op=0000 a=F b=3 → second response `rsp_y`=3, `rsp_v`=0 (stale carry masked).
- Both requesters valid continuously for 4 ops (req0 op=0101, req1 op=0001) → grants in order 0,1,0,1; `rsp_valid` alternates 01,10,01,10; `reqN_ready` never both high.
- Requester 1: op=1010 a=7 b=0 → `rsp_err`=1, `rsp_y`=0, `rsp_v`=0. Same with op=0111 → `rsp_err`=1. Op=1010 a=7 b=3 → `rsp_y`=1, `rsp_err`=0.
- `rsp_ready` low 5 cycles in RESP with requester 1 valid → `rsp_*` stable, `req1_ready`=0, `busy`=1. Raise `rsp_ready` → requester 1 accepted one cycle after IDLE.
- Assert `rst` mid-EXEC, then mid-RESP → immediately `busy`=0, `rsp_valid`=00, `alu_op`=0, `done_cnt`=0. After release, both valid → requester 0 granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the request, response and ALU-side signals of alu_arbiter.
//   req0_*/req1_* : per-requester valid/ready handshake with operands a, b and opcode op
//   rsp_*         : one-hot response valid, per-requester ready, result y, flag v, error err
//   alu_*         : registered operands/opcode to the external ALU and its y/v outputs
// Modports:
//   slave  : the arbiter side
//   master : the clients plus the external ALU
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [3:0] req0_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [3:0] req1_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_y;
  logic       rsp_v;
  logic       rsp_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [3:0] alu_y;
  logic       alu_v;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_y, alu_v,
    output req0_ready, req1_ready, rsp_valid, rsp_y, rsp_v, rsp_err,
    output alu_a, alu_b, alu_op
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output rsp_ready, alu_y, alu_v,
    input  req0_ready, req1_ready, rsp_valid, rsp_y, rsp_v, rsp_err,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational 4-bit ALU between two
// requesters. One operation at a time: IDLE (accept) -> EXEC (ALU settles) -> RESP (held
// response until the owner takes it).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : alu_arbiter_if.slave (request/response handshakes and ALU wiring)
//   busy     : high whenever not IDLE
//   done_cnt : completed-response counter, wraps 255 -> 0
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic [7:0]   done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e     state_q;
  logic       last_q;   // requester served last; resets to 1 so requester 0 is favoured
  logic       owner_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] op_q;
  logic [3:0] y_q;
  logic       v_q;
  logic       err_q;
  logic [1:0] rsp_valid_q;
  logic       busy_q;
  logic [7:0] done_q;

  logic       gnt0;
  logic       gnt1;
  logic [3:0] y_d;
  logic       v_d;
  logic       err_d;
  logic       take;

  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    take = bus.rsp_ready[owner_q];

    err_d = (op_q == 4'b0111) || ((op_q == 4'b1010) && (b_q == '0));
    y_d   = bus.alu_y;
    // The ALU leaves v stale for ops that do not define it; pass it only for
    // add, sub, shift-left and shift-right.
    v_d   = 1'b0;
    case (op_q)
      4'b1000, 4'b1001, 4'b1011, 4'b1100: v_d = bus.alu_v;
      default:                            v_d = 1'b0;
    endcase
    if (err_d) begin
      y_d = '0;
      v_d = 1'b0;
    end
  end

  assign bus.req0_ready = (state_q == IDLE) & gnt0;
  assign bus.req1_ready = (state_q == IDLE) & gnt1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_y      = y_q;
  assign bus.rsp_v      = v_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign busy           = busy_q;
  assign done_cnt       = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      y_q         <= '0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            a_q     <= gnt1 ? bus.req1_a  : bus.req0_a;
            b_q     <= gnt1 ? bus.req1_b  : bus.req0_b;
            op_q    <= gnt1 ? bus.req1_op : bus.req0_op;
            owner_q <= gnt1;
            last_q  <= gnt1;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          y_q         <= y_d;
          v_q         <= v_d;
          err_q       <= err_d;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (take) begin
            done_q      <= done_q + 8'd1;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small behavioural ALU that
// deliberately reports v=1 for ops that do not define it.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] done_cnt;
  logic [7:0] exp_done;
  logic [4:0] ext;
  int         checks   = 0;
  int         failures = 0;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: and/or/xor, add, sub (borrow), mod, shl, shr; else ~a with v=1.
  always_comb begin
    ext        = '0;
    bus.alu_y  = ~bus.alu_a;
    bus.alu_v  = 1'b1;
    case (bus.alu_op)
      4'b0000: bus.alu_y = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_y = bus.alu_a | bus.alu_b;
      4'b0101: bus.alu_y = bus.alu_a ^ bus.alu_b;
      4'b1000: begin
        ext       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_y = ext[3:0];
        bus.alu_v = ext[4];
      end
      4'b1001: begin
        ext       = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_y = ext[3:0];
        bus.alu_v = ext[4];
      end
      4'b1010: bus.alu_y = (bus.alu_b != '0) ? (bus.alu_a % bus.alu_b) : 4'hF;
      4'b1011: begin
        bus.alu_y = {bus.alu_a[2:0], 1'b0};
        bus.alu_v = bus.alu_a[3];
      end
      4'b1100: begin
        bus.alu_y = {1'b0, bus.alu_a[3:1]};
        bus.alu_v = bus.alu_a[0];
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op);
    if (r == 0) begin
      bus.req0_valid = v;
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_op    = op;
    end else begin
      bus.req1_valid = v;
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_op    = op;
    end
  endtask

  // One complete operation from IDLE with rsp_ready held at 11.
  task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] ey, input logic ev,
                       input logic eerr, input string tag);
    set_req(r, 1'b1, a, b, op);
    #1;
    chk({tag, ".ready"}, (r == 0) ? bus.req0_ready : bus.req1_ready, 32'd1);
    chk({tag, ".other_ready"}, (r == 0) ? bus.req1_ready : bus.req0_ready, 32'd0);
    tick();
    set_req(r, 1'b0, a, b, op);
    chk({tag, ".exec_busy"}, busy, 32'd1);
    chk({tag, ".exec_rsp_valid"}, bus.rsp_valid, 32'd0);
    chk({tag, ".alu_op"}, bus.alu_op, op);
    tick();
    chk({tag, ".rsp_valid"}, bus.rsp_valid, (r == 0) ? 32'd1 : 32'd2);
    chk({tag, ".rsp_y"}, bus.rsp_y, ey);
    chk({tag, ".rsp_v"}, bus.rsp_v, ev);
    chk({tag, ".rsp_err"}, bus.rsp_err, eerr);
    tick();
    exp_done = exp_done + 8'd1;
    chk({tag, ".idle_rsp_valid"}, bus.rsp_valid, 32'd0);
    chk({tag, ".idle_busy"}, busy, 32'd0);
    chk({tag, ".done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.rsp_ready = 2'b00;
    exp_done      = '0;
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    #2;
    chk("rst.busy", busy, 32'd0);
    chk("rst.rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst.rsp_y", bus.rsp_y, 32'd0);
    chk("rst.alu_a", bus.alu_a, 32'd0);
    chk("rst.alu_b", bus.alu_b, 32'd0);
    chk("rst.alu_op", bus.alu_op, 32'd0);
    chk("rst.done_cnt", done_cnt, 32'd0);
    chk("rst.req0_ready", bus.req0_ready, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.rsp_ready = 2'b11;

    // Add with carry-out.
    do_op(0, 4'h9, 4'h8, 4'b1000, 4'h1, 1'b1, 1'b0, "t1_add");
    // Add, then AND on requester 1 whose stale v must be masked.
    do_op(0, 4'h9, 4'h8, 4'b1000, 4'h1, 1'b1, 1'b0, "t2_add");
    do_op(1, 4'hF, 4'h3, 4'b0000, 4'h3, 1'b0, 1'b0, "t2_and");

    // Both valid continuously: grants alternate 0,1,0,1.
    set_req(0, 1'b1, 4'h6, 4'h3, 4'b0101);
    set_req(1, 1'b1, 4'h5, 4'hA, 4'b0001);
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk("rr.req0_ready", bus.req0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr.req1_ready", bus.req1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr.both_ready", bus.req0_ready & bus.req1_ready, 32'd0);
      tick();
      chk("rr.alu_op", bus.alu_op, (i % 2 == 0) ? 32'h5 : 32'h1);
      tick();
      chk("rr.rsp_valid", bus.rsp_valid, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr.rsp_y", bus.rsp_y, (i % 2 == 0) ? 32'h5 : 32'hF);
      chk("rr.rsp_v", bus.rsp_v, 32'd0);
      tick();
      exp_done = exp_done + 8'd1;
      chk("rr.done_cnt", done_cnt, exp_done);
    end
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);

    // Error cases and flag-carrying ops.
    do_op(1, 4'h7, 4'h0, 4'b1010, 4'h0, 1'b0, 1'b1, "t4_mod0");
    do_op(1, 4'h7, 4'h3, 4'b0111, 4'h0, 1'b0, 1'b1, "t4_undef");
    do_op(1, 4'h7, 4'h3, 4'b1010, 4'h1, 1'b0, 1'b0, "t4_mod");
    do_op(0, 4'h3, 4'h5, 4'b1001, 4'hE, 1'b1, 1'b0, "t4_sub");
    do_op(0, 4'h9, 4'h0, 4'b1011, 4'h2, 1'b1, 1'b0, "t4_shl");
    do_op(1, 4'h9, 4'h0, 4'b1100, 4'h4, 1'b1, 1'b0, "t4_shr");

    // Backpressure in RESP with requester 1 waiting; non-owner ready is ignored.
    bus.rsp_ready = 2'b00;
    set_req(0, 1'b1, 4'h1, 4'h2, 4'b1000);
    #1;
    chk("bp.req0_ready", bus.req0_ready, 32'd1);
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    set_req(1, 1'b1, 4'h4, 4'h4, 4'b0001);
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", bus.rsp_valid, 32'd1);
      chk("bp.rsp_y", bus.rsp_y, 32'h3);
      chk("bp.rsp_v", bus.rsp_v, 32'd0);
      chk("bp.rsp_err", bus.rsp_err, 32'd0);
      chk("bp.req1_ready", bus.req1_ready, 32'd0);
      chk("bp.busy", busy, 32'd1);
      bus.rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
      tick();
    end
    chk("bp.done_hold", done_cnt, exp_done);
    bus.rsp_ready = 2'b01;
    tick();
    exp_done = exp_done + 8'd1;
    chk("bp.done_cnt", done_cnt, exp_done);
    chk("bp.idle_busy", busy, 32'd0);
    chk("bp.idle_rsp_valid", bus.rsp_valid, 32'd0);
    chk("bp.req1_ready_idle", bus.req1_ready, 32'd1);
    tick();
    chk("bp.req1_accept_busy", busy, 32'd1);
    chk("bp.req1_alu_op", bus.alu_op, 32'h1);
    set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    bus.rsp_ready = 2'b11;
    tick();
    chk("bp.req1_rsp_valid", bus.rsp_valid, 32'd2);
    chk("bp.req1_rsp_y", bus.rsp_y, 32'h4);
    tick();
    exp_done = exp_done + 8'd1;
    chk("bp.req1_done", done_cnt, exp_done);

    // Reset during EXEC.
    set_req(0, 1'b1, 4'h9, 4'h8, 4'b1000);
    #1;
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    chk("rx.pre_alu_op", bus.alu_op, 32'h8);
    rst = 1'b1;
    #1;
    exp_done = '0;
    chk("rx.busy", busy, 32'd0);
    chk("rx.rsp_valid", bus.rsp_valid, 32'd0);
    chk("rx.alu_op", bus.alu_op, 32'd0);
    chk("rx.done_cnt", done_cnt, 32'd0);
    #2;
    rst = 1'b0;
    tick();

    // Reset during RESP.
    bus.rsp_ready = 2'b00;
    set_req(0, 1'b1, 4'h9, 4'h8, 4'b1000);
    #1;
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    chk("rr2.pre_rsp_valid", bus.rsp_valid, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr2.busy", busy, 32'd0);
    chk("rr2.rsp_valid", bus.rsp_valid, 32'd0);
    chk("rr2.rsp_y", bus.rsp_y, 32'd0);
    chk("rr2.rsp_v", bus.rsp_v, 32'd0);
    chk("rr2.alu_op", bus.alu_op, 32'd0);
    chk("rr2.done_cnt", done_cnt, 32'd0);
    #2;
    rst = 1'b0;
    tick();

    // After reset both valid: requester 0 wins.
    set_req(0, 1'b1, 4'h2, 4'h3, 4'b0000);
    set_req(1, 1'b1, 4'hC, 4'h3, 4'b0001);
    #1;
    chk("post.req0_ready", bus.req0_ready, 32'd1);
    chk("post.req1_ready", bus.req1_ready, 32'd0);
    tick();
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    chk("post.alu_a", bus.alu_a, 32'h2);
    bus.rsp_ready = 2'b11;
    tick();
    chk("post.rsp_y", bus.rsp_y, 32'h2);
    tick();
    exp_done = exp_done + 8'd1;
    chk("post.done_cnt", done_cnt, exp_done);

    // Run the counter through its 255 -> 0 wrap.
    for (int unsigned i = 0; i < 255; i++) begin
      do_op(0, 4'h1, 4'h1, 4'b1000, 4'h2, 1'b0, 1'b0, "t7_wrap");
    end
    chk("wrap.zero", done_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
